// File: rtl/magic_button_ctrl.sv
// Magic (service menu) button front end: synchronise, debounce, and classify
// presses as short (menu request) or long (reboot request) using frame ticks.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// IDLE         | waiting for a debounced press; all outputs low
// PRESSED      | button held; counting frame ticks toward the long threshold
// ARMED        | short press seen; magic_button high until ack or timeout
// REBOOT       | long press seen; reboot_req high for REBOOT_FRAMES ticks
// WAIT_RELEASE | long press done; swallow the release so it is not a short press
module magic_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 560000,
    parameter int LONG_FRAMES     = 100,
    parameter int ARM_FRAMES      = 4,
    parameter int REBOOT_FRAMES   = 2
) (
    input  logic clk28,
    input  logic rst_n,
    input  logic n_button_raw,
    input  logic n_int,
    input  logic magic_mode,
    output logic magic_button,
    output logic reboot_req,
    output logic btn_pressed
);

    localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  LONG_F   = 8'(LONG_FRAMES);
    localparam logic [7:0]  ARM_F    = 8'(ARM_FRAMES);
    localparam logic [7:0]  REBOOT_F = 8'(REBOOT_FRAMES);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESSED      = 3'd1,
        ARMED        = 3'd2,
        REBOOT       = 3'd3,
        WAIT_RELEASE = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  sync_q;
    logic [19:0] deb_cnt;
    logic        btn_q;
    logic        int_q;
    logic [7:0]  fcnt;
    logic        frame_tick;
    logic        btn_rise;

    assign frame_tick = int_q & ~n_int;
    assign btn_rise   = btn_pressed & ~btn_q;

    // Raw input is active low, so "stable" means synced level == ~btn_pressed.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            deb_cnt     <= '0;
            btn_pressed <= 1'b0;
            btn_q       <= 1'b0;
            int_q       <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], n_button_raw};
            btn_q  <= btn_pressed;
            int_q  <= n_int;
            if (sync_q[1] == ~btn_pressed) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt     <= '0;
                btn_pressed <= ~btn_pressed;
            end else begin
                deb_cnt <= deb_cnt + 20'd1;
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                fcnt <= '0;
            end else if (frame_tick && (fcnt != 8'hFF)) begin
                fcnt <= fcnt + 8'd1;
            end
        end
    end

    // Long threshold is tested before release, and ack before timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (btn_rise) state_next = PRESSED;
            end
            PRESSED: begin
                if (fcnt == LONG_F)   state_next = REBOOT;
                else if (!btn_pressed) state_next = magic_mode ? IDLE : ARMED;
            end
            ARMED: begin
                if (magic_mode)          state_next = IDLE;
                else if (fcnt == ARM_F)  state_next = IDLE;
            end
            REBOOT: begin
                if (fcnt == REBOOT_F) state_next = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!btn_pressed) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        magic_button = 1'b0;
        reboot_req   = 1'b0;
        case (state)
            ARMED:   magic_button = 1'b1;
            REBOOT:  reboot_req   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_magic_button_ctrl.sv
// Directed, table-driven bench for magic_button_ctrl with short debounce and
// frame thresholds so full press classifications fit in a few hundred cycles.
module tb_magic_button_ctrl;

    localparam int DEB = 8;
    localparam int LONG = 5;
    localparam int ARM = 4;
    localparam int REB = 2;

    logic clk28 = 1'b0;
    logic rst_n;
    logic n_button_raw;
    logic n_int;
    logic magic_mode;
    logic magic_button;
    logic reboot_req;
    logic btn_pressed;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        logic  raw;
        logic  mode;
        int    idle;
        int    ticks;
        logic  mb;
        logic  rr;
        logic  bp;
    } vec_t;

    vec_t tbl[$];

    magic_button_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_FRAMES    (LONG),
        .ARM_FRAMES     (ARM),
        .REBOOT_FRAMES  (REB)
    ) dut (
        .clk28       (clk28),
        .rst_n       (rst_n),
        .n_button_raw(n_button_raw),
        .n_int       (n_int),
        .magic_mode  (magic_mode),
        .magic_button(magic_button),
        .reboot_req  (reboot_req),
        .btn_pressed (btn_pressed)
    );

    always #5 clk28 = ~clk28;

    function automatic vec_t mk(string name, logic raw, logic mode, int idle, int ticks,
                                logic mb, logic rr, logic bp);
        vec_t v;
        v.name = name; v.raw = raw; v.mode = mode; v.idle = idle; v.ticks = ticks;
        v.mb = mb; v.rr = rr; v.bp = bp;
        return v;
    endfunction

    task automatic check(string name, string sig, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0b expected %0b at %0t", name, sig, act, exp, $time);
        end
    endtask

    task automatic check_outs(string name, logic mb, logic rr, logic bp);
        check(name, "magic_button", magic_button, mb);
        check(name, "reboot_req", reboot_req, rr);
        check(name, "btn_pressed", btn_pressed, bp);
    endtask

    // Called right after a falling edge; a tick is one low cycle of n_int then one high.
    task automatic run_vec(vec_t v);
        n_button_raw = v.raw;
        magic_mode   = v.mode;
        n_int        = 1'b1;
        repeat (v.idle) @(negedge clk28);
        repeat (v.ticks) begin
            n_int = 1'b0;
            @(negedge clk28);
            n_int = 1'b1;
            @(negedge clk28);
        end
        check_outs(v.name, v.mb, v.rr, v.bp);
    endtask

    task automatic pulse_reset(string name);
        rst_n = 1'b0;
        #1;
        check_outs(name, 1'b0, 1'b0, 1'b0);
        @(negedge clk28);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        n_button_raw = 1'b1;
        n_int        = 1'b1;
        magic_mode   = 1'b0;
        repeat (3) @(negedge clk28);
        rst_n = 1'b1;

        tbl.push_back(mk("reset",        1, 0, 3, 0, 0, 0, 0));
        // glitches shorter than the debounce window
        tbl.push_back(mk("glitch5",      0, 0, 5, 0, 0, 0, 0));
        tbl.push_back(mk("glitch5_rel",  1, 0, 12, 1, 0, 0, 0));
        tbl.push_back(mk("glitch7",      0, 0, 7, 0, 0, 0, 0));
        tbl.push_back(mk("glitch7_rel",  1, 0, 12, 1, 0, 0, 0));
        tbl.push_back(mk("glitch3",      0, 0, 3, 0, 0, 0, 0));
        tbl.push_back(mk("glitch3_rel",  1, 0, 12, 1, 0, 0, 0));
        // short press acknowledged by magic_mode
        tbl.push_back(mk("sp_deb_m1",    0, 0, 9, 0, 0, 0, 0));
        tbl.push_back(mk("sp_deb",       0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk("sp_hold",      0, 0, 1, 3, 0, 0, 1));
        tbl.push_back(mk("sp_rel_m1",    1, 0, 9, 0, 0, 0, 1));
        tbl.push_back(mk("sp_rel",       1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("sp_armed",     1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk("sp_tick",      1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk("sp_ack",       1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk("sp_after",     1, 0, 3, 0, 0, 0, 0));
        // long press
        tbl.push_back(mk("lp_deb",       0, 0, 11, 0, 0, 0, 1));
        tbl.push_back(mk("lp_thr_m1",    0, 0, 0, 4, 0, 0, 1));
        tbl.push_back(mk("lp_reboot",    0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk("lp_reboot2",   0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk("lp_rb_end",    0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk("lp_wait",      0, 0, 0, 3, 0, 0, 1));
        tbl.push_back(mk("lp_rel",       1, 0, 10, 0, 0, 0, 0));
        tbl.push_back(mk("lp_no_mb",     1, 0, 3, 0, 0, 0, 0));
        // menu already active
        tbl.push_back(mk("menu_deb",     0, 1, 11, 2, 0, 0, 1));
        tbl.push_back(mk("menu_rel",     1, 1, 10, 0, 0, 0, 0));
        tbl.push_back(mk("menu_no_mb",   1, 1, 2, 0, 0, 0, 0));
        tbl.push_back(mk("menu_clear",   1, 0, 3, 0, 0, 0, 0));
        // ack timeout, then a normal press
        tbl.push_back(mk("to_deb",       0, 0, 11, 0, 0, 0, 1));
        tbl.push_back(mk("to_armed",     1, 0, 11, 0, 1, 0, 0));
        tbl.push_back(mk("to_tick3",     1, 0, 0, 3, 1, 0, 0));
        tbl.push_back(mk("to_tick4",     1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("to_no_retry",  1, 0, 0, 3, 0, 0, 0));
        tbl.push_back(mk("to2_deb",      0, 0, 11, 0, 0, 0, 1));
        tbl.push_back(mk("to2_armed",    1, 0, 11, 0, 1, 0, 0));
        tbl.push_back(mk("to2_ack",      1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk("to2_after",    1, 0, 1, 0, 0, 0, 0));
        // long threshold and release land on the same cycle: long wins
        tbl.push_back(mk("sim_deb",      0, 0, 11, 4, 0, 0, 1));
        tbl.push_back(mk("sim_rel_m1",   1, 0, 9, 0, 0, 0, 1));
        tbl.push_back(mk("sim_long",     1, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk("sim_rb_end",   1, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk("sim_idle",     1, 0, 3, 0, 0, 0, 0));
        // ack and timeout in the same cycle
        tbl.push_back(mk("simack_deb",   0, 0, 11, 0, 0, 0, 1));
        tbl.push_back(mk("simack_arm",   1, 0, 11, 3, 1, 0, 0));
        tbl.push_back(mk("simack_both",  1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk("simack_after", 1, 0, 2, 0, 0, 0, 0));

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset mid-ARMED with a second press still held.
        run_vec(mk("ra_deb",    0, 0, 11, 0, 0, 0, 1));
        run_vec(mk("ra_armed",  1, 0, 11, 0, 1, 0, 0));
        run_vec(mk("ra_ignore", 0, 0, 11, 0, 1, 0, 1));
        pulse_reset("ra_reset");
        run_vec(mk("ra_deb_m1", 0, 0, 9, 0, 0, 0, 0));
        run_vec(mk("ra_deb2",   0, 0, 1, 0, 0, 0, 1));
        run_vec(mk("ra_hold",   0, 0, 1, 2, 0, 0, 1));
        run_vec(mk("ra_rel",    1, 0, 11, 0, 1, 0, 0));
        run_vec(mk("ra_ack",    1, 1, 1, 0, 0, 0, 0));
        run_vec(mk("ra_after",  1, 0, 1, 0, 0, 0, 0));

        // Reset mid-REBOOT with the button still held.
        run_vec(mk("rr_deb",    0, 0, 11, 0, 0, 0, 1));
        run_vec(mk("rr_reboot", 0, 0, 0, 5, 0, 1, 1));
        pulse_reset("rr_reset");
        run_vec(mk("rr_deb2",   0, 0, 11, 0, 0, 0, 1));
        run_vec(mk("rr_thr_m1", 0, 0, 0, 4, 0, 0, 1));
        run_vec(mk("rr_reboot2",0, 0, 0, 1, 0, 1, 1));
        run_vec(mk("rr_rb_end", 0, 0, 0, 2, 0, 0, 1));
        run_vec(mk("rr_rel",    1, 0, 12, 0, 0, 0, 0));
        run_vec(mk("rr_idle",   1, 0, 3, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/magic_button_ctrl.md
# magic_button_ctrl

Front-end controller for the magic (service menu) button. It synchronises and debounces the raw board button and classifies each press as short or long, using the frame interrupt as its timebase. A short press drives `magic_button` into the `magic` block and holds it until `magic_mode` acknowledges entry. A long press raises `reboot_req` to the reset generator instead of entering the menu.

## Interface
- `DEBOUNCE_CYCLES`, default 560000: clk28 cycles the synced input must be stable before the debounced level changes (20 ms); must fit 20 bits.
- `LONG_FRAMES`, default 100: frame ticks of continuous press that make a long press (2 s at 50 Hz); range 2..255.
- `ARM_FRAMES`, default 4: frame ticks `magic_button` may stay high without acknowledge before it is dropped; range 1..255.
- `REBOOT_FRAMES`, default 2: frame ticks `reboot_req` is held high; range 1..255.
- `clk28`  in  1  system clock, 28 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `n_button_raw`  in  1  raw button, active low, asynchronous to clk28.
- `n_int`  in  1  frame interrupt, active low; its falling edge is the frame tick.
- `magic_mode`  in  1  acknowledge from `magic`; high while the menu is active.
- `magic_button`  out  1  menu request to `magic`.
- `reboot_req`  out  1  reboot request to the reset generator.
- `btn_pressed`  out  1  debounced button level, 1 = pressed (status).

## Operation
- Synchroniser: two flops on `n_button_raw`, reset value 1 (released).
- Debounce:
  - A 20-bit counter clears whenever the synced input equals `btn_pressed` (inverted polarity).
  - Otherwise it increments. On reaching `DEBOUNCE_CYCLES-1`, `btn_pressed` toggles and the counter clears.
- Frame tick: one-cycle pulse when registered `n_int` = 1 and current `n_int` = 0.
- An 8-bit frame counter `fcnt` clears on every state change and increments on each tick, saturating at 255.
- States:
  - IDLE: all outputs low. On the `btn_pressed` rising edge, go to PRESSED.
  - PRESSED:
    - When `fcnt` reaches `LONG_FRAMES`, go to REBOOT.
    - Otherwise, if `btn_pressed` falls: if `magic_mode` = 1 (menu already active), go to IDLE and drop the request; else go to ARMED.
  - ARMED: `magic_button` = 1.
    - On `magic_mode` = 1, go to IDLE.
    - On `fcnt` = `ARM_FRAMES`, go to IDLE (timeout, no retry).
    - A new press is ignored in this state.
  - REBOOT: `reboot_req` = 1. On `fcnt` = `REBOOT_FRAMES`, go to WAIT_RELEASE.
  - WAIT_RELEASE: outputs low. When `btn_pressed` = 0, go to IDLE, so the release of a long press never produces a short press.
- Simultaneous events:
  - In PRESSED, reaching the long threshold wins over a release in the same cycle.
  - In ARMED, an acknowledge wins over a timeout in the same cycle.
- Reset, including mid-operation: state IDLE, all counters 0, all outputs 0, synchroniser 1, `btn_pressed` 0, registered `n_int` 1. A button still held after reset must produce a fresh rising edge through the debouncer (`DEBOUNCE_CYCLES` of stable input) before any action.

## Timing
- All outputs are registered and change on the `clk28` rising edge.
- Press-to-`btn_pressed` latency: 2 sync cycles + `DEBOUNCE_CYCLES`.
- `btn_pressed` falling edge to `magic_button` = 1: 1 cycle (PRESSED→ARMED registered).
- `magic_mode` = 1 to `magic_button` = 0: 1 cycle.
- The tick that brings `fcnt` to the threshold, to `reboot_req` = 1: 1 cycle.
- `reboot_req` width: exactly `REBOOT_FRAMES` frame ticks, measured from the entry cycle to the cycle after the last counted tick.
- `magic` samples `magic_button` on the `n_int` falling edge. `magic_button` therefore stays high across at least one tick unless acknowledged, and `ARM_FRAMES` ≥ 1 guarantees this.

## Test plan
- Glitch rejection: pulse `n_button_raw` low for 1000 cycles three times → `btn_pressed` stays 0, state stays IDLE, no outputs.
- Short press: hold low for 30 frames, then release, with a `magic_mode` model that goes to 1 at the next tick while `magic_button` is high.
  - `magic_button` rises 1 cycle after debounced release.
  - `magic_button` falls 1 cycle after `magic_mode` = 1.
  - `reboot_req` never asserted.
- Long press: hold low for 150 frames.
  - `reboot_req` high for exactly 2 ticks, starting at the 100th tick.
  - No `magic_button` on release; state returns to IDLE after the debounced release.
- Already in menu: `magic_mode` = 1, short press → `magic_button` stays 0, state returns to IDLE.
- Ack timeout: short press with `magic_mode` tied 0 → `magic_button` high until the 4th tick, then 0, no retry. A following press behaves normally.
- Reset mid-ARMED and mid-REBOOT with the button still held: `rst_n` low → outputs 0 immediately. After reset, `reboot_req`/`magic_button` reappear only after a full debounce and a new classification.
